// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one saturating event counter between two
// requesters: grant, clear, count owner strobes, pulse done at MAX.
module counter_arbiter #(
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [1:0]       req,
   input  logic [1:0]       x,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic [CNT_W-1:0] q,
   output logic [1:0]       g
);

   typedef enum logic [1:0] {
      IDLE,
      CLR,
      COUNT,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] MAX = '1;
   localparam logic [CNT_W-1:0] PRE = MAX - 1'b1;

   state_t           state;
   state_t           state_n;
   logic             owner;
   logic             owner_n;
   logic             last;
   logic             last_n;
   logic [1:0]       gnt_n;
   logic [1:0]       g_n;
   logic [CNT_W-1:0] q_n;
   logic             busy_n;
   logic             win;

   // Reset leaves last=1 so requester 0 wins the first tie.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         gnt   <= '0;
         g     <= '0;
         q     <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         owner <= owner_n;
         last  <= last_n;
         gnt   <= gnt_n;
         g     <= g_n;
         q     <= q_n;
         busy  <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      owner_n = owner;
      last_n  = last;
      gnt_n   = gnt;
      g_n     = '0;
      q_n     = q;
      win     = 1'b0;

      unique case (state)
         IDLE: begin
            gnt_n = '0;
            unique case (1'b1)
               (req == 2'b11): win = ~last;
               (req == 2'b10): win = 1'b1;
               (req == 2'b01): win = 1'b0;
               default:        win = 1'b0;
            endcase
            if (req != 2'b00) begin
               owner_n = win;
               last_n  = win;
               gnt_n   = win ? 2'b10 : 2'b01;
               state_n = CLR;
            end
         end
         CLR: begin
            q_n     = '0;
            state_n = COUNT;
         end
         COUNT: begin
            // A dropped request wins over a same-cycle strobe.
            if (!req[owner]) begin
               gnt_n   = '0;
               state_n = IDLE;
            end else if (x[owner] && q != MAX) begin
               q_n = q + 1'b1;
               if (q == PRE) begin
                  g_n     = gnt;
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            gnt_n   = '0;
            state_n = IDLE;
         end
         default: begin
            gnt_n   = '0;
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule
